// File: rtl/pll_drp_reconfig.sv
// Purpose: DRP read-modify-write sequencer that holds the PLL in reset around a batch of register updates and waits for relock.
// Latency: RST_HOLD cycles of PLL reset before the first access; 4 cycles per access plus DRP response time; relock wait after release.
// Backpressure: req_ready is high only in IDLE and NEXT; requests are held off for the whole of every access and the relock wait.
//
// Ports:
//   dclk, rst_n                      clock (also the DRP clock), asynchronous active-low reset
//   req_valid/req_ready              request handshake
//   req_addr/req_mask/req_data/req_last
//                                    DRP address, keep-mask (1 = keep old bit), new data, last request of the batch
//   daddr/den/dwe/di                 DRP initiator outputs
//   drp_do/drdy                      DRP read data and access-complete strobe ("do" is a reserved word)
//   pll_rst                          PLL reset, active high
//   locked                           PLL lock indication
//   busy/done/error                  batch in progress / one-cycle completion pulse / sticky failure flag
module pll_drp_reconfig #(
    parameter int RST_HOLD     = 4,
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic        dclk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [6:0]  req_addr,
    input  logic [15:0] req_mask,
    input  logic [15:0] req_data,
    input  logic        req_last,
    output logic [6:0]  daddr,
    output logic        den,
    output logic        dwe,
    output logic [15:0] di,
    input  logic [15:0] drp_do,
    input  logic        drdy,
    output logic        pll_rst,
    input  logic        locked,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [3:0] {
        IDLE, HOLD, READ, WAIT_RD, WRITE, WAIT_WR, NEXT, RELEASE, WAIT_LOCK
    } state_t;

    // One counter serves the reset hold and all three wait states; 16 bits
    // covers the largest legal LOCK_TIMEOUT.
    localparam int CW = 16;
    localparam logic [CW-1:0] HOLD_LAST = CW'(RST_HOLD - 1);
    localparam logic [CW-1:0] DRDY_LAST = CW'(DRDY_TIMEOUT - 1);
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TIMEOUT - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_sat;
    logic [6:0]    addr_q;
    logic [15:0]   mask_q;
    logic [15:0]   data_q;
    logic          last_q;

    assign cnt_sat = (&cnt) ? cnt : cnt + 1'b1;

    always_ff @(posedge dclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            mask_q    <= '0;
            data_q    <= '0;
            last_q    <= 1'b0;
            req_ready <= 1'b0;
            daddr     <= '0;
            den       <= 1'b0;
            dwe       <= 1'b0;
            di        <= '0;
            pll_rst   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        addr_q    <= req_addr;
                        mask_q    <= req_mask;
                        data_q    <= req_data;
                        last_q    <= req_last;
                        req_ready <= 1'b0;
                        error     <= 1'b0;
                        busy      <= 1'b1;
                        pll_rst   <= 1'b1;
                        cnt       <= '0;
                        state     <= HOLD;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt >= HOLD_LAST) begin
                        den   <= 1'b1;
                        dwe   <= 1'b0;
                        daddr <= addr_q;
                        state <= READ;
                    end else begin
                        cnt <= cnt_sat;
                    end
                end
                READ: begin
                    den   <= 1'b0;
                    cnt   <= '0;
                    state <= WAIT_RD;
                end
                WAIT_RD: begin
                    // DRDY is checked before the timeout so a response on the
                    // final allowed cycle still counts.
                    if (drdy) begin
                        den   <= 1'b1;
                        dwe   <= 1'b1;
                        di    <= (drp_do & mask_q) | (data_q & ~mask_q);
                        state <= WRITE;
                    end else if (cnt >= DRDY_LAST) begin
                        error   <= 1'b1;
                        pll_rst <= 1'b0;
                        state   <= RELEASE;
                    end else begin
                        cnt <= cnt_sat;
                    end
                end
                WRITE: begin
                    den   <= 1'b0;
                    dwe   <= 1'b0;
                    cnt   <= '0;
                    state <= WAIT_WR;
                end
                WAIT_WR: begin
                    if (drdy) begin
                        if (last_q) begin
                            pll_rst <= 1'b0;
                            state   <= RELEASE;
                        end else begin
                            req_ready <= 1'b1;
                            state     <= NEXT;
                        end
                    end else if (cnt >= DRDY_LAST) begin
                        error   <= 1'b1;
                        pll_rst <= 1'b0;
                        state   <= RELEASE;
                    end else begin
                        cnt <= cnt_sat;
                    end
                end
                NEXT: begin
                    // Follow-on request: PLL is already in reset, so the read
                    // starts at once using the address straight off the port.
                    if (req_valid && req_ready) begin
                        addr_q    <= req_addr;
                        mask_q    <= req_mask;
                        data_q    <= req_data;
                        last_q    <= req_last;
                        req_ready <= 1'b0;
                        den       <= 1'b1;
                        dwe       <= 1'b0;
                        daddr     <= req_addr;
                        state     <= READ;
                    end
                end
                RELEASE: begin
                    cnt   <= '0;
                    state <= WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    // The first cycle is skipped so a stale LOCKED from before
                    // the release cannot end the wait.
                    if ((cnt != '0) && locked) begin
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end else if (cnt >= LOCK_LAST) begin
                        error     <= 1'b1;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt_sat;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pll_drp_reconfig.sv
module tb_pll_drp_reconfig;

    typedef struct packed {
        logic [6:0]  a;
        logic [15:0] d;
    } wr_t;

    logic        dclk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [6:0]  req_addr = '0;
    logic [15:0] req_mask = '0;
    logic [15:0] req_data = '0;
    logic        req_last = 1'b0;
    logic [6:0]  daddr;
    logic        den;
    logic        dwe;
    logic [15:0] di;
    logic [15:0] drp_do;
    logic        drdy;
    logic        pll_rst;
    logic        locked = 1'b0;
    logic        busy;
    logic        done;
    logic        error;

    int n_cmp = 0;
    int n_err = 0;

    always #5 dclk = ~dclk;

    pll_drp_reconfig #(
        .RST_HOLD(4),
        .DRDY_TIMEOUT(64),
        .LOCK_TIMEOUT(100)
    ) dut (
        .dclk(dclk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_mask(req_mask), .req_data(req_data), .req_last(req_last),
        .daddr(daddr), .den(den), .dwe(dwe), .di(di),
        .drp_do(drp_do), .drdy(drdy),
        .pll_rst(pll_rst), .locked(locked),
        .busy(busy), .done(done), .error(error)
    );

    // ---------------- DRP slave model ----------------
    logic [15:0] mem [128];
    logic        drdy_q = 1'b0;
    logic        inject = 1'b0;
    bit          p_den = 1'b0;
    bit          model_en = 1'b1;
    assign drp_do = mem[daddr];
    assign drdy   = drdy_q | inject;

    // DRDY arrives the cycle after the DEN cycle.
    always @(negedge dclk) begin
        drdy_q = p_den && model_en;
        p_den  = den;
    end

    // PLL model: LOCKED rises 10 cycles after PLL_RST falls.
    int lk = 0;
    bit lock_en = 1'b1;
    always @(negedge dclk) begin
        if (pll_rst) begin
            lk     = 0;
            locked = 1'b0;
        end else begin
            if (lk < 1000) lk++;
            locked = lock_en && (lk >= 10);
        end
    end

    // ---------------- monitor ----------------
    wr_t  exp_q[$];
    wr_t  obs_q[$];
    logic dwe_log[$];
    int   cyc = 0, den_cnt = 0, rise_cnt = 0, fall_cnt = 0, done_cnt = 0;
    int   rise_cyc = 0, first_rd_cyc = 0;
    bit   rd_seen = 1'b0, prev_rst = 1'b0;
    wr_t  mon_w;

    always @(negedge dclk) begin
        cyc++;
        if (pll_rst && !prev_rst) begin
            rise_cnt++;
            rise_cyc = cyc;
            rd_seen  = 1'b0;
        end
        if (!pll_rst && prev_rst) fall_cnt++;
        prev_rst = pll_rst;
        if (den) begin
            den_cnt++;
            dwe_log.push_back(dwe);
            if (!dwe && !rd_seen) begin
                rd_seen      = 1'b1;
                first_rd_cyc = cyc;
            end
            if (dwe) begin
                mon_w.a = daddr;
                mon_w.d = di;
                obs_q.push_back(mon_w);
                mem[daddr] = di;
            end
        end
        if (done) done_cnt++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_req(input logic [6:0] a, input logic [15:0] m, input logic [15:0] d,
                            input logic l, input bit push, output bit ok);
        wr_t e;
        @(negedge dclk);
        req_valid = 1'b1;
        req_addr  = a;
        req_mask  = m;
        req_data  = d;
        req_last  = l;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            if (req_ready) ok = 1'b1;
            else @(negedge dclk);
        end
        if (ok && push) begin
            e.a = a;
            e.d = (mem[a] & m) | (d & ~m);
            exp_q.push_back(e);
        end
        @(posedge dclk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge dclk);
            if (done) seen = 1'b1;
        end
    endtask

    task automatic wait_den(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge dclk);
            if (den) seen = 1'b1;
        end
    endtask

    task automatic wait_ready(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge dclk);
            if (req_ready) seen = 1'b1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge dclk);
        n_cmp++;
        if ({req_ready, den, dwe, daddr, di, pll_rst, busy, done, error} !== 30'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got rdy=%b den=%b dwe=%b daddr=%h di=%h rst=%b busy=%b done=%b err=%b, want all 0",
                     req_ready, den, dwe, daddr, di, pll_rst, busy, done, error);
        end
        rst_n = 1'b1;
        @(negedge dclk);
        n_cmp++;
        if ({req_ready, busy} !== 2'b10) begin
            n_err++;
            $display("FAIL reset_ready: got rdy=%b busy=%b, want rdy=1 busy=0", req_ready, busy);
        end
    endtask

    task automatic test_single();
        bit ok, seen;
        int d0, dn0;
        wr_t e, o;
        d0 = den_cnt; dn0 = done_cnt;
        dwe_log.delete();
        send_req(7'h08, 16'hFF00, 16'h1234, 1'b1, 1'b1, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL single_accept: ready never seen, want accepted"); end
        wait_done(300, seen);
        n_cmp++;
        if (!seen) begin n_err++; $display("FAIL single_done: no DONE within 300 cycles, want DONE"); end
        n_cmp++;
        if ({error, busy, pll_rst} !== 3'b000) begin
            n_err++;
            $display("FAIL single_end_flags: got err=%b busy=%b rst=%b, want 0 0 0", error, busy, pll_rst);
        end
        repeat (2) @(negedge dclk);
        n_cmp++;
        if (done !== 1'b0 || done_cnt - dn0 != 1) begin
            n_err++;
            $display("FAIL single_done_pulse: got done=%b pulses=%0d, want 0 and 1", done, done_cnt - dn0);
        end
        n_cmp++;
        if (first_rd_cyc - rise_cyc != 4) begin
            n_err++;
            $display("FAIL single_hold: got %0d cycles of PLL_RST before DEN, want 4", first_rd_cyc - rise_cyc);
        end
        n_cmp++;
        if (den_cnt - d0 != 2 || dwe_log.size() != 2) begin
            n_err++;
            $display("FAIL single_den_count: got %0d, want 2", den_cnt - d0);
        end else if (dwe_log[0] !== 1'b0 || dwe_log[1] !== 1'b1) begin
            n_err++;
            $display("FAIL single_den_order: got dwe %b,%b want 0,1", dwe_log[0], dwe_log[1]);
        end
        n_cmp++;
        if (obs_q.size() == 0) begin
            n_err++;
            $display("FAIL single_wr_val: got no write, want 08/a534");
        end else if (obs_q[0].a !== 7'h08 || obs_q[0].d !== 16'hA534) begin
            n_err++;
            $display("FAIL single_wr_val: got %h/%h, want 08/a534", obs_q[0].a, obs_q[0].d);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_err++;
                $display("FAIL single_sb: got no write, want %h/%h", e.a, e.d);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_err++;
                    $display("FAIL single_sb: got %h/%h, want %h/%h", o.a, o.d, e.a, e.d);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok1, ok2, ok3, seen, rdy;
        int d0, r0, f0;
        logic [5:0] pat;
        wr_t e, o;
        d0 = den_cnt; r0 = rise_cnt; f0 = fall_cnt;
        dwe_log.delete();
        send_req(7'h10, 16'h00FF, 16'hBEEF, 1'b0, 1'b1, ok1);
        wait_ready(100, rdy);
        repeat (5) @(negedge dclk);
        n_cmp++;
        if (!rdy || {pll_rst, busy, req_ready} !== 3'b111) begin
            n_err++;
            $display("FAIL batch_gap: got rdy_seen=%b rst=%b busy=%b rdy=%b, want 1 1 1 1", rdy, pll_rst, busy, req_ready);
        end
        send_req(7'h11, 16'hF0F0, 16'h1357, 1'b0, 1'b1, ok2);
        send_req(7'h12, 16'h0000, 16'hCAFE, 1'b1, 1'b1, ok3);
        n_cmp++;
        if (!(ok1 && ok2 && ok3)) begin
            n_err++;
            $display("FAIL batch_accept: got %b%b%b, want 111", ok1, ok2, ok3);
        end
        wait_done(400, seen);
        repeat (2) @(negedge dclk);
        n_cmp++;
        if (!seen || error !== 1'b0) begin
            n_err++;
            $display("FAIL batch_done: got done_seen=%b err=%b, want 1 0", seen, error);
        end
        for (int i = 0; i < 6; i++) pat[5-i] = (i < dwe_log.size()) ? dwe_log[i] : 1'bx;
        n_cmp++;
        if (den_cnt - d0 != 6 || pat !== 6'b010101) begin
            n_err++;
            $display("FAIL batch_den: got %0d pulses dwe=%b, want 6 and 010101", den_cnt - d0, pat);
        end
        n_cmp++;
        if (rise_cnt - r0 != 1 || fall_cnt - f0 != 1) begin
            n_err++;
            $display("FAIL batch_pll_rst: got %0d rises %0d falls, want 1 1", rise_cnt - r0, fall_cnt - f0);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_err++;
                $display("FAIL batch_sb: got no write, want %h/%h", e.a, e.d);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_err++;
                    $display("FAIL batch_sb: got %h/%h, want %h/%h", o.a, o.d, e.a, e.d);
                end
            end
        end
    endtask

    task automatic test_drdy_timeout();
        bit ok, seen;
        int d0, dn0;
        d0 = den_cnt; dn0 = done_cnt;
        model_en = 1'b0;
        send_req(7'h20, 16'h0F0F, 16'h4444, 1'b1, 1'b0, ok);
        wait_den(50, seen);
        n_cmp++;
        if (!seen) begin n_err++; $display("FAIL to_read: got no DEN, want read strobe"); end
        repeat (64) @(negedge dclk);
        n_cmp++;
        if ({error, pll_rst} !== 2'b01) begin
            n_err++;
            $display("FAIL to_early: got err=%b rst=%b at wait cycle 64, want 0 1", error, pll_rst);
        end
        @(negedge dclk);
        n_cmp++;
        if ({error, pll_rst, done} !== 3'b100) begin
            n_err++;
            $display("FAIL to_expire: got err=%b rst=%b done=%b, want 1 0 0", error, pll_rst, done);
        end
        model_en = 1'b1;
        wait_done(300, seen);
        n_cmp++;
        if (!seen || error !== 1'b1) begin
            n_err++;
            $display("FAIL to_done: got done_seen=%b err=%b, want 1 1", seen, error);
        end
        repeat (2) @(negedge dclk);
        n_cmp++;
        if (den_cnt - d0 != 1 || done_cnt - dn0 != 1 || obs_q.size() != 0) begin
            n_err++;
            $display("FAIL to_abort: got den=%0d done=%0d writes=%0d, want 1 1 0",
                     den_cnt - d0, done_cnt - dn0, obs_q.size());
        end
    endtask

    task automatic test_lock_timeout();
        bit ok, rel;
        wr_t e, o;
        lock_en = 1'b0;
        send_req(7'h21, 16'hFFFF, 16'h0000, 1'b1, 1'b1, ok);
        rel = 1'b0;
        for (int i = 0; i < 300 && !rel; i++) begin
            @(negedge dclk);
            if (!pll_rst) rel = 1'b1;
        end
        n_cmp++;
        if (!rel || error !== 1'b0) begin
            n_err++;
            $display("FAIL lk_release: got released=%b err=%b, want 1 0", rel, error);
        end
        repeat (100) @(negedge dclk);
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL lk_early: got done=%b at 99 cycles, want 0", done);
        end
        @(negedge dclk);
        n_cmp++;
        if ({done, error, busy} !== 3'b110) begin
            n_err++;
            $display("FAIL lk_expire: got done=%b err=%b busy=%b, want 1 1 0", done, error, busy);
        end
        @(negedge dclk);
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL lk_pulse: got done=%b, want 0", done);
        end
        lock_en = 1'b1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_err++;
                $display("FAIL lk_sb: got no write, want %h/%h", e.a, e.d);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_err++;
                    $display("FAIL lk_sb: got %h/%h, want %h/%h", o.a, o.d, e.a, e.d);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok, seen;
        wr_t e, o;
        model_en = 1'b0;
        send_req(7'h30, 16'h00FF, 16'h9999, 1'b1, 1'b0, ok);
        wait_den(50, seen);
        @(negedge dclk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({req_ready, den, dwe, daddr, di, pll_rst, busy, done, error} !== 30'd0) begin
            n_err++;
            $display("FAIL mid_reset: got rdy=%b den=%b dwe=%b daddr=%h di=%h rst=%b busy=%b done=%b err=%b, want all 0",
                     req_ready, den, dwe, daddr, di, pll_rst, busy, done, error);
        end
        @(negedge dclk);
        rst_n = 1'b1;
        model_en = 1'b1;
        @(negedge dclk);
        n_cmp++;
        if (req_ready !== 1'b1 || obs_q.size() != 0) begin
            n_err++;
            $display("FAIL mid_recover: got rdy=%b writes=%0d, want 1 0", req_ready, obs_q.size());
        end
        send_req(7'h31, 16'h0FF0, 16'h5A5A, 1'b1, 1'b1, ok);
        wait_done(300, seen);
        n_cmp++;
        if (!seen || error !== 1'b0) begin
            n_err++;
            $display("FAIL mid_next_batch: got done_seen=%b err=%b, want 1 0", seen, error);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_err++;
                $display("FAIL mid_sb: got no write, want %h/%h", e.a, e.d);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_err++;
                    $display("FAIL mid_sb: got %h/%h, want %h/%h", o.a, o.d, e.a, e.d);
                end
            end
        end
    endtask

    task automatic test_spurious_drdy();
        bit ok, seen;
        int d1;
        wr_t e, o;
        @(negedge dclk);
        inject = 1'b1;
        @(negedge dclk);
        inject = 1'b0;
        @(negedge dclk);
        n_cmp++;
        if ({req_ready, busy, den, pll_rst, done} !== 5'b10000) begin
            n_err++;
            $display("FAIL spur_idle: got rdy=%b busy=%b den=%b rst=%b done=%b, want 1 0 0 0 0",
                     req_ready, busy, den, pll_rst, done);
        end
        send_req(7'h40, 16'hFF00, 16'h0011, 1'b0, 1'b1, ok);
        wait_ready(100, seen);
        d1 = den_cnt;
        inject = 1'b1;
        @(negedge dclk);
        inject = 1'b0;
        repeat (3) @(negedge dclk);
        n_cmp++;
        if (!seen || {req_ready, busy, den, pll_rst} !== 4'b1101 || den_cnt != d1) begin
            n_err++;
            $display("FAIL spur_next: got rdy=%b busy=%b den=%b rst=%b extra_den=%0d, want 1 1 0 1 0",
                     req_ready, busy, den, pll_rst, den_cnt - d1);
        end
        send_req(7'h41, 16'h0000, 16'h7777, 1'b1, 1'b1, ok);
        wait_done(300, seen);
        n_cmp++;
        if (!seen || error !== 1'b0) begin
            n_err++;
            $display("FAIL spur_done: got done_seen=%b err=%b, want 1 0", seen, error);
        end
        // DRDY on the 64th wait cycle: response must win over the timeout.
        model_en = 1'b0;
        send_req(7'h50, 16'h00FF, 16'hABCD, 1'b1, 1'b1, ok);
        wait_den(50, seen);
        repeat (64) @(negedge dclk);
        inject = 1'b1;
        model_en = 1'b1;
        @(negedge dclk);
        inject = 1'b0;
        n_cmp++;
        if ({den, dwe, error} !== 3'b110) begin
            n_err++;
            $display("FAIL race_write: got den=%b dwe=%b err=%b, want 1 1 0", den, dwe, error);
        end
        wait_done(300, seen);
        n_cmp++;
        if (!seen || error !== 1'b0) begin
            n_err++;
            $display("FAIL race_done: got done_seen=%b err=%b, want 1 0", seen, error);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_err++;
                $display("FAIL spur_sb: got no write, want %h/%h", e.a, e.d);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_err++;
                    $display("FAIL spur_sb: got %h/%h, want %h/%h", o.a, o.d, e.a, e.d);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 16'(i * 16'h0101) ^ 16'h5A3C;
        mem[8] = 16'hA5A5;
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_drdy_timeout();
        test_lock_timeout();
        test_reset_mid();
        test_spurious_drdy();
        repeat (2) @(negedge dclk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end

endmodule

// File: doc/pll_drp_reconfig.md
PLL_DRP_RECONFIG -- requirements
Module: pll_drp_reconfig

Interface
REQ-001 Parameter RST_HOLD, default 4: number of DCLK cycles PLL_RST is held high before the first DRP access of a batch (range 1..255).
REQ-002 Parameter DRDY_TIMEOUT, default 64: maximum number of DCLK cycles to wait for DRDY after a DEN strobe.
REQ-003 Parameter LOCK_TIMEOUT, default 65535: maximum number of DCLK cycles to wait for LOCKED after PLL_RST is released.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset; ports are listed below as name, direction, width, meaning.
REQ-005 DCLK  in  1  the single clock; also the DRP clock.
REQ-006 RST_N  in  1  asynchronous active-low reset.
REQ-007 REQ_VALID / REQ_READY  in / out  1 / 1  request handshake.
REQ-008 REQ_ADDR / REQ_MASK / REQ_DATA / REQ_LAST  in  7 / 16 / 16 / 1  DRP address, keep-mask (1 = keep old bit), new data, last request of the batch.
REQ-009 DADDR / DEN / DWE / DI  out  7 / 1 / 1 / 16  DRP initiator outputs.
REQ-010 DO / DRDY  in  16 / 1  DRP read data and access-complete strobe.
REQ-011 PLL_RST  out  1  PLL reset, active high.
REQ-012 LOCKED  in  1  PLL lock indication.
REQ-013 BUSY / DONE / ERROR  out  1 / 1 / 1  batch in progress / one-cycle completion pulse / sticky failure flag.

Function
REQ-014 States: IDLE, HOLD, READ, WAIT_RD, WRITE, WAIT_WR, NEXT, RELEASE, WAIT_LOCK.
REQ-015 REQ_READY SHALL be 1 only in IDLE and NEXT; a request is accepted on the rising DCLK edge where REQ_VALID and REQ_READY are both 1, and ADDR/MASK/DATA/LAST are registered at that edge.
REQ-016 Acceptance in IDLE: clear ERROR, set BUSY, set PLL_RST, go to HOLD; HOLD lasts exactly RST_HOLD cycles, then go to READ.
REQ-017 Acceptance in NEXT: go directly to READ; PLL_RST stays 1.
REQ-018 READ: one cycle with DEN=1, DWE=0, DADDR=registered address; then WAIT_RD.
REQ-019 WAIT_RD: on DRDY=1, capture DO and go to WRITE.
REQ-020 WRITE: one cycle with DEN=1, DWE=1, DADDR unchanged, DI=(DO_captured AND MASK) OR (DATA AND NOT MASK); then WAIT_WR.
REQ-021 WAIT_WR: on DRDY=1, go to RELEASE if LAST=1, otherwise to NEXT.
REQ-022 NEXT: wait indefinitely for a request, holding PLL_RST=1 and BUSY=1.
REQ-023 RELEASE: one cycle; PLL_RST driven 0 from this state onward; then WAIT_LOCK.
REQ-024 WAIT_LOCK: LOCKED is sampled starting with the second cycle in this state; on LOCKED=1 pulse DONE for one cycle, clear BUSY, go to IDLE.
REQ-025 DEN SHALL be high for exactly one cycle per access; DRDY arriving in any state other than WAIT_RD or WAIT_WR SHALL be ignored.
REQ-026 Timeout counter: cleared on entry to WAIT_RD, WAIT_WR and WAIT_LOCK, incremented each cycle in those states, and saturating.
REQ-027 DRDY_TIMEOUT cycles in WAIT_RD or WAIT_WR without DRDY: set ERROR and go to RELEASE, aborting the batch.
REQ-028 LOCK_TIMEOUT cycles in WAIT_LOCK without LOCKED: set ERROR, pulse DONE, go to IDLE.
REQ-029 DRDY and timeout expiry in the same cycle: DRDY wins and no error is set.
REQ-030 ERROR stays 1 until the next batch is accepted in IDLE.
REQ-031 DADDR and DI SHALL hold their last driven value while DEN=0.

Reset
REQ-032 While RST_N=0, all of the following SHALL hold asynchronously: state=IDLE, REQ_READY=0, DEN=0, DWE=0, DADDR=0, DI=0, PLL_RST=0, BUSY=0, DONE=0, ERROR=0, counters=0.
REQ-033 REQ_READY SHALL become 1 on the first DCLK edge after RST_N rises.
REQ-034 Reset asserted mid-batch SHALL abort without completing the DRP access; PLL_RST drops to 0 immediately.

Verification
REQ-035 Single write: DRP model returns DO=16'hA5A5 one cycle after DEN; request ADDR=7'h08, MASK=16'hFF00, DATA=16'h1234, LAST=1 -> PLL_RST high 4 cycles before first DEN; write DI=16'hA534 to 7'h08; LOCKED raised 10 cycles after release -> one DONE pulse, ERROR=0.
REQ-036 Three-request batch with a 5-cycle gap before request 2 -> PLL_RST stays 1 throughout; exactly 6 DEN pulses in read/write order; a single RST_HOLD interval.
REQ-037 DRDY never returned -> ERROR=1 after 64 wait cycles; PLL_RST falls; batch aborted; no DONE until lock or lock timeout.
REQ-038 LOCKED held 0 with LOCK_TIMEOUT=100 -> DONE and ERROR=1 exactly 100 cycles after entering WAIT_LOCK.
REQ-039 RST_N pulsed low during WAIT_RD -> all outputs return to reset values immediately; the next batch completes normally.
REQ-040 A spurious DRDY in IDLE or NEXT, and DRDY coinciding with the 64th wait cycle -> no state change in the first case, no ERROR in the second.
